// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake crossing.
// Holds a captured word on o_data while o_req is up; synchronizes i_ack locally.
module cdc_handshake_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  src_clk,
  input  logic                  src_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    ack_s_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept;
  logic                    to_hit;
  logic                    req_d, ready_d, done_d, timeout_d;
  logic [DATA_WIDTH-1:0]   data_d;

  // Acknowledge synchronizer; ack_s_nxt is the value ack_s takes after this edge
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], i_ack};
  end

  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign ack_s_nxt = sync_q[SYNC_STAGES-2];

  assign accept = (state_q == S_IDLE) && i_valid && o_ready;
  assign to_hit = TO_EN && (cnt_q == CNT_LIM);

  // State register
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; ack has priority over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ:  if (ack_s || to_hit) state_d = S_DROP;
      S_DROP: if (!ack_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the REQ cycle counter
  always_comb begin
    req_d     = o_req;
    data_d    = o_data;
    done_d    = 1'b0;
    timeout_d = o_timeout;
    cnt_d     = cnt_q;
    ready_d   = (state_d == S_IDLE) && !ack_s_nxt;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = i_data;
          req_d  = 1'b1;
          cnt_d  = '0;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          req_d = 1'b0;
        end else if (to_hit) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      S_DROP: begin
        if (!ack_s) done_d = 1'b1;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      o_ready   <= 1'b0;
      o_req     <= 1'b0;
      o_data    <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      cnt_q     <= '0;
    end else begin
      o_ready   <= ready_d;
      o_req     <= req_d;
      o_data    <= data_d;
      o_done    <= done_d;
      o_timeout <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx (SYNC_STAGES=2, TIMEOUT_CYCLES=5).
module tb_cdc_handshake_tx;

  logic       src_clk = 1'b0;
  logic       src_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_data = 8'h00;
  logic       o_req;
  logic [7:0] o_data;
  logic       i_ack;
  logic       o_done;
  logic       o_timeout;

  logic man_ack  = 1'b0;
  logic resp_en  = 1'b0;
  logic resp_ack = 1'b0;
  logic req_seen = 1'b0;

  assign i_ack = resp_en ? resp_ack : man_ack;

  cdc_handshake_tx #(
    .DATA_WIDTH    (8),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(5)
  ) dut (
    .src_clk  (src_clk),
    .src_rst_n(src_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_req    (o_req),
    .o_data   (o_data),
    .i_ack    (i_ack),
    .o_done   (o_done),
    .o_timeout(o_timeout)
  );

  initial forever #5 src_clk = ~src_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Destination responder: echoes o_req back as ack one cycle late
  initial forever begin
    @(posedge src_clk);
    #1;
    resp_ack = req_seen;
    req_seen = o_req;
  end

  // Monitor: scores every completion and checks o_data stability while o_req is up
  logic       prev_req = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial forever begin
    exp_t e;
    @(negedge src_clk);
    if (src_rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_data", 32'(o_data), 32'(e.data));
        chk("done_timeout", 32'(o_timeout), 32'(e.to));
      end
    end
    if (o_req && prev_req) chk("data_stable", 32'(o_data), 32'(prev_data));
    prev_req  = o_req;
    prev_data = o_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] words [3];
    logic       acc;
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;

    // Reset with i_valid high
    i_valid = 1'b1;
    i_data  = 8'h5A;
    repeat (3) tick();
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    src_rst_n = 1'b1;
    i_valid   = 1'b0;
    tick();
    chk("rel_ready", 32'(o_ready), 32'd1);

    // Single transfer with exact handshake timing
    i_data  = 8'hA5;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    exp_q.push_back('{data: 8'hA5, to: 1'b0});
    chk("single_req_up", 32'(o_req), 32'd1);
    chk("single_data", 32'(o_data), 32'hA5);
    chk("single_ready_low", 32'(o_ready), 32'd0);
    man_ack = 1'b1;
    tick();
    chk("single_req_a0", 32'(o_req), 32'd1);
    tick();
    chk("single_req_a1", 32'(o_req), 32'd1);
    tick();
    chk("single_req_fall", 32'(o_req), 32'd0);
    man_ack = 1'b0;
    tick();
    chk("single_done_f0", 32'(o_done), 32'd0);
    tick();
    chk("single_done_f1", 32'(o_done), 32'd0);
    tick();
    chk("single_done", 32'(o_done), 32'd1);
    chk("single_done_ready", 32'(o_ready), 32'd1);
    tick();
    chk("single_done_pulse", 32'(o_done), 32'd0);
    tick();
    chk("idle_data_hold", 32'(o_data), 32'hA5);

    // Back-to-back through the responder
    resp_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      i_data  = words[w];
      i_valid = 1'b1;
      acc     = 1'b0;
      for (int c = 0; c < 40 && !acc; c++) begin
        acc = o_ready;
        tick();
      end
      if (acc) exp_q.push_back('{data: words[w], to: 1'b0});
      else     chk("b2b_accept", 32'd0, 32'd1);
    end
    i_valid = 1'b0;
    wait_empty(100, "b2b_drain");
    tick();
    resp_en = 1'b0;

    // Stale ack held from reset
    src_rst_n = 1'b0;
    man_ack   = 1'b1;
    repeat (2) tick();
    src_rst_n = 1'b1;
    repeat (4) tick();
    chk("stale_ready", 32'(o_ready), 32'd0);
    i_data  = 8'h77;
    i_valid = 1'b1;
    repeat (3) tick();
    chk("stale_no_req", 32'(o_req), 32'd0);
    chk("stale_ready2", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    man_ack = 1'b0;
    tick();
    chk("stale_ready_f0", 32'(o_ready), 32'd0);
    tick();
    chk("stale_ready_f1", 32'(o_ready), 32'd1);
    chk("stale_data", 32'(o_data), 32'd0);

    // Timeout without any ack
    i_data  = 8'hC3;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    exp_q.push_back('{data: 8'hC3, to: 1'b1});
    repeat (5) tick();
    chk("to_req_held", 32'(o_req), 32'd1);
    chk("to_flag_low", 32'(o_timeout), 32'd0);
    tick();
    chk("to_req_fall", 32'(o_req), 32'd0);
    chk("to_flag_set", 32'(o_timeout), 32'd1);
    tick();
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_data", 32'(o_data), 32'hC3);
    tick();

    // Successful transfer keeps the sticky timeout flag
    resp_en = 1'b1;
    i_data  = 8'h3C;
    i_valid = 1'b1;
    acc     = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = o_ready;
      tick();
    end
    i_valid = 1'b0;
    if (acc) exp_q.push_back('{data: 8'h3C, to: 1'b1});
    else     chk("sticky_accept", 32'd0, 32'd1);
    wait_empty(60, "sticky_drain");
    chk("sticky_flag", 32'(o_timeout), 32'd1);
    tick();
    resp_en = 1'b0;

    // Reset in the middle of REQ
    i_data  = 8'h99;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("mid_req_up", 32'(o_req), 32'd1);
    src_rst_n = 1'b0;
    tick();
    chk("mid_req_down", 32'(o_req), 32'd0);
    chk("mid_ready", 32'(o_ready), 32'd0);
    chk("mid_data", 32'(o_data), 32'd0);
    chk("mid_timeout", 32'(o_timeout), 32'd0);
    src_rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(o_ready), 32'd1);
    repeat (8) tick();
    chk("mid_no_done", 32'(o_done), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
